// File: rtl/mix_mem_arbiter.sv
// mix_mem_arbiter
//   Shares the single-port 4096 x 31-bit MIX main memory between the CPU and
//   the block-I/O transfer unit. At most one access is granted per cycle. The
//   CPU normally has priority. A saturating wait counter stops the I/O unit
//   from being starved. A one-cycle CPU lock covers the read-modify-write
//   sequence used by partial-field stores. Read data is routed back to
//   whichever requester issued the read.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-high reset
//   cpu_req/we/lock   CPU request, write enable, lock-next-cycle (with a read)
//   cpu_addr/wdata    CPU word address and write data
//   cpu_gnt           CPU access accepted this cycle (combinational)
//   cpu_rvalid/rdata  CPU read return, one cycle after a granted read
//   io_req/we         I/O request and write enable
//   io_addr/wdata     I/O word address and write data
//   io_gnt            I/O access accepted this cycle (combinational)
//   io_rvalid/rdata   I/O read return, one cycle after a granted read
//   mem_en/we         memory strobe and write enable
//   mem_addr/wdata    memory address and write data
//   mem_rdata         registered memory read data (valid cycle after a read)
//
// Handshake: a requester raises *_req with stable we/addr/wdata and holds it
// until the cycle in which *_gnt is 1; that cycle is the access. A granted
// read returns exactly one cycle later with *_rvalid=1 for a single cycle.
// Writes return nothing. *_rdata reads 0 whenever its *_rvalid is 0.

module mix_mem_arbiter #(
  parameter int AW          = 12,
  parameter int DW          = 31,
  parameter int IO_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_lock,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          io_req,
  input  logic          io_we,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_gnt,
  output logic          io_rvalid,
  output logic [DW-1:0] io_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Owner of the read data arriving from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_IO   = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(IO_MAX_WAIT);

  logic       lock_pend, lock_pend_nxt;
  logic [3:0] wait_cnt,  wait_cnt_nxt;
  owner_t     rv_owner,  rv_owner_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_pend <= 1'b0;
      wait_cnt  <= 4'd0;
      rv_owner  <= OWN_NONE;
    end else begin
      lock_pend <= lock_pend_nxt;
      wait_cnt  <= wait_cnt_nxt;
      rv_owner  <= rv_owner_nxt;
    end
  end

  // Grant decision and next state. Grants depend only on requests and
  // registered state, never on mem_rdata.
  always_comb begin
    cpu_gnt       = 1'b0;
    io_gnt        = 1'b0;
    lock_pend_nxt = 1'b0;
    wait_cnt_nxt  = 4'd0;
    rv_owner_nxt  = OWN_NONE;

    if (!reset) begin
      if (lock_pend) begin
        // Reserved cycle: the I/O side is held off even if the CPU is idle.
        cpu_gnt = cpu_req;
      end else if (io_req && (wait_cnt == WAIT_MAX)) begin
        io_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (io_req) begin
        io_gnt = 1'b1;
      end
    end

    // A lock is only taken outside a lock cycle, so it never chains.
    lock_pend_nxt = cpu_gnt & ~cpu_we & cpu_lock & ~lock_pend;

    // Lock cycles also count as denied cycles, so a starved I/O request
    // wins on the first cycle after the lock.
    if (io_req && !io_gnt) begin
      wait_cnt_nxt = (wait_cnt < WAIT_MAX) ? wait_cnt + 4'd1 : wait_cnt;
    end

    if (cpu_gnt && !cpu_we) begin
      rv_owner_nxt = OWN_CPU;
    end else if (io_gnt && !io_we) begin
      rv_owner_nxt = OWN_IO;
    end
  end

  // Memory port mux.
  assign mem_en    = cpu_gnt | io_gnt;
  assign mem_we    = io_gnt ? io_we    : (cpu_gnt & cpu_we);
  assign mem_addr  = io_gnt ? io_addr  : cpu_addr;
  assign mem_wdata = io_gnt ? io_wdata : cpu_wdata;

  // Read return routing; an in-flight return is dropped while in reset.
  assign cpu_rvalid = ~reset & (rv_owner == OWN_CPU);
  assign io_rvalid  = ~reset & (rv_owner == OWN_IO);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign io_rdata   = io_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mix_mem_arbiter.sv
module tb_mix_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req = 0, cpu_we = 0, cpu_lock = 0;
  logic [11:0] cpu_addr = '0;
  logic [30:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [30:0] cpu_rdata;
  logic        io_req = 0, io_we = 0;
  logic [11:0] io_addr = '0;
  logic [30:0] io_wdata = '0;
  logic        io_gnt, io_rvalid;
  logic [30:0] io_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [30:0] mem_wdata;
  logic [30:0] mem_rdata = '0;

  mix_mem_arbiter #(.AW(12), .DW(31), .IO_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- memory environment ----------------
  logic [30:0] ram    [4096];
  logic [30:0] shadow [4096];   // bench's own model of memory contents
  logic        load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) ram[i] <= shadow[i];
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [30:0] cpu_exp_q[$];
  logic [30:0] io_exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read returns: an expected entry pushed at a grant must come back on the
  // following cycle; with nothing queued, rvalid and rdata must be 0.
  always @(posedge clk) begin
    #2;
    if (cpu_exp_q.size() > 0) begin
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
    end else begin
      chk("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
      chk("cpu_rdata_idle", 32'(cpu_rdata), 32'd0);
    end
    if (io_exp_q.size() > 0) begin
      chk("io_rvalid", 32'(io_rvalid), 32'd1);
      chk("io_rdata", 32'(io_rdata), 32'(io_exp_q.pop_front()));
    end else begin
      chk("io_rvalid_idle", 32'(io_rvalid), 32'd0);
      chk("io_rdata_idle", 32'(io_rdata), 32'd0);
    end
  end

  // ---------------- driver ----------------
  // One bus cycle: drive requests, check the grant at the falling edge,
  // update the model, then move to just after the next rising edge.
  task automatic step(input string tag,
                      input logic c_req, input logic c_we, input logic c_lock,
                      input logic [11:0] c_addr, input logic [30:0] c_wd,
                      input logic i_req, input logic i_we,
                      input logic [11:0] i_addr, input logic [30:0] i_wd,
                      input logic e_c, input logic e_i);
    cpu_req = c_req; cpu_we = c_we; cpu_lock = c_lock;
    cpu_addr = c_addr; cpu_wdata = c_wd;
    io_req = i_req; io_we = i_we; io_addr = i_addr; io_wdata = i_wd;
    @(negedge clk);
    chk({tag, "/cpu_gnt"}, 32'(cpu_gnt), 32'(e_c));
    chk({tag, "/io_gnt"},  32'(io_gnt),  32'(e_i));
    chk({tag, "/mem_en"},  32'(mem_en),  32'(e_c | e_i));
    if (e_c) begin
      chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(c_addr));
      chk({tag, "/mem_we"},   32'(mem_we),   32'(c_we));
      if (c_we) begin
        chk({tag, "/mem_wdata"}, 32'(mem_wdata), 32'(c_wd));
        shadow[c_addr] = c_wd;
      end else begin
        cpu_exp_q.push_back(shadow[c_addr]);
      end
    end else if (e_i) begin
      chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(i_addr));
      chk({tag, "/mem_we"},   32'(mem_we),   32'(i_we));
      if (i_we) begin
        chk({tag, "/mem_wdata"}, 32'(mem_wdata), 32'(i_wd));
        shadow[i_addr] = i_wd;
      end else begin
        io_exp_q.push_back(shadow[i_addr]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 12'h000, '0, 0, 0, 12'h000, '0, 0, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = 31'($urandom);
    shadow[12'h005] = 31'h4000_0003;

    // Reset with both requesters asserting: nothing may be granted.
    load = 1'b1; reset = 1'b1; cpu_req = 1'b1; io_req = 1'b1;
    @(negedge clk);
    chk("rst/cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst/io_gnt",  32'(io_gnt),  32'd0);
    chk("rst/mem_en",  32'(mem_en),  32'd0);
    chk("rst/mem_we",  32'(mem_we),  32'd0);
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; io_req = 1'b0;
    chk("rst/lock_pend", 32'(dut.lock_pend), 32'd0);
    chk("rst/wait_cnt",  32'(dut.wait_cnt),  32'd0);

    idle("idle0");
    step("cpu_rd_005", 1, 0, 0, 12'h005, '0, 0, 0, 12'h000, '0, 1, 0);
    idle("cpu_rd_005_ret");

    // Starvation: CPU holds the bus, I/O wins on its fifth request cycle.
    for (int k = 0; k < 4; k++)
      step($sformatf("starve_c%0d", k), 1, 0, 0, 12'(16 + k), '0,
           1, 1, 12'h020, 31'h0123_4567, 1, 0);
    chk("starve/wait_sat", 32'(dut.wait_cnt), 32'd4);
    step("starve_c4", 1, 0, 0, 12'h014, '0, 1, 1, 12'h020, 31'h0123_4567, 0, 1);
    chk("starve/wait_clr", 32'(dut.wait_cnt), 32'd0);
    step("starve_c5", 1, 0, 0, 12'h014, '0, 0, 0, 12'h000, '0, 1, 0);
    step("starve_rd20", 1, 0, 0, 12'h020, '0, 0, 0, 12'h000, '0, 1, 0);

    // Locked read-modify-write with a nearly starved I/O request.
    for (int k = 0; k < 3; k++)
      step($sformatf("lk_pre%0d", k), 1, 0, 0, 12'(64 + k), '0,
           1, 0, 12'h050, '0, 1, 0);
    chk("lk/wait3", 32'(dut.wait_cnt), 32'd3);
    step("lk_rd", 1, 0, 1, 12'h044, '0, 1, 0, 12'h050, '0, 1, 0);
    chk("lk/lock_set", 32'(dut.lock_pend), 32'd1);
    chk("lk/wait4", 32'(dut.wait_cnt), 32'd4);
    step("lk_wr", 1, 1, 0, 12'h044, 31'h2AAA_5555, 1, 0, 12'h050, '0, 1, 0);
    chk("lk/lock_clr", 32'(dut.lock_pend), 32'd0);
    step("lk_io", 0, 0, 0, 12'h000, '0, 1, 0, 12'h050, '0, 0, 1);
    step("lk_rd44", 1, 0, 0, 12'h044, '0, 0, 0, 12'h000, '0, 1, 0);

    // Lock with no CPU follow-up: the reserved cycle stays idle.
    step("nf_rd", 1, 0, 1, 12'h060, '0, 0, 0, 12'h000, '0, 1, 0);
    step("nf_lock", 0, 0, 0, 12'h000, '0, 1, 1, 12'h061, 31'h0ABC_DEF0, 0, 0);
    chk("nf/lock_clr", 32'(dut.lock_pend), 32'd0);
    step("nf_io", 0, 0, 0, 12'h000, '0, 1, 1, 12'h061, 31'h0ABC_DEF0, 0, 1);
    step("nf_rd61", 1, 0, 0, 12'h061, '0, 0, 0, 12'h000, '0, 1, 0);

    // Top address, written by I/O and read back by the CPU.
    step("io_wr_fff", 0, 0, 0, 12'h000, '0, 1, 1, 12'hFFF, 31'h7FFF_FFFF, 0, 1);
    step("cpu_rd_fff", 1, 0, 0, 12'hFFF, '0, 0, 0, 12'h000, '0, 1, 0);

    // Read then write of the same word: the read sees the old value.
    step("bb_rd", 1, 0, 0, 12'h030, '0, 0, 0, 12'h000, '0, 1, 0);
    step("bb_wr", 0, 0, 0, 12'h000, '0, 1, 1, 12'h030, 31'h5555_AAAA, 0, 1);
    step("bb_rd2", 1, 0, 0, 12'h030, '0, 1, 0, 12'h030, '0, 1, 0);
    step("bb_io_rd", 0, 0, 0, 12'h000, '0, 1, 0, 12'h030, '0, 0, 1);

    // Reset right after a locked CPU read: lock and return are discarded.
    step("rst_rd", 1, 0, 1, 12'h070, '0, 1, 0, 12'h071, '0, 1, 0);
    reset = 1'b1;
    cpu_exp_q.delete();
    @(negedge clk);
    chk("midrst/cpu_gnt",    32'(cpu_gnt),    32'd0);
    chk("midrst/io_gnt",     32'(io_gnt),     32'd0);
    chk("midrst/mem_en",     32'(mem_en),     32'd0);
    chk("midrst/cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; io_req = 1'b0;
    @(negedge clk);
    chk("postrst/mem_en",    32'(mem_en),        32'd0);
    chk("postrst/cpu_gnt",   32'(cpu_gnt),       32'd0);
    chk("postrst/lock_pend", 32'(dut.lock_pend), 32'd0);
    chk("postrst/wait_cnt",  32'(dut.wait_cnt),  32'd0);
    @(posedge clk); #1;
    step("postrst_io", 0, 0, 0, 12'h000, '0, 1, 0, 12'h071, '0, 0, 1);
    idle("final0");
    idle("final1");

    // ---------------- report ----------------
    chk("end/cpu_q_empty", 32'(cpu_exp_q.size()), 32'd0);
    chk("end/io_q_empty",  32'(io_exp_q.size()),  32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
